// File: rtl/m_wb_uart_pkg.sv
// Shared definitions for the Wishbone UART: register map, status bit positions
// and the 2-bit state encoding used by both the TX and RX state machines.
package m_wb_uart_pkg;

  localparam logic AddrData   = 1'b0;
  localparam logic AddrStatus = 1'b1;

  localparam int unsigned StatRxValid = 0;
  localparam int unsigned StatTxFull  = 1;
  localparam int unsigned StatTxBusy  = 2;
  localparam int unsigned StatOverrun = 3;
  localparam int unsigned StatFramErr = 4;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StStart = 2'd1,
    StData  = 2'd2,
    StStop  = 2'd3
  } uart_state_e;

endpackage

// File: rtl/m_uart_rx.sv
// 8N1 receiver: synchronises the line, qualifies the start bit at mid-bit and
// samples each following bit at its centre; pulses o_done or o_ferr per frame.
module m_uart_rx
  import m_wb_uart_pkg::*;
#(
  parameter int unsigned CLKDIV = 208
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_rx,
  output logic       o_done,
  output logic       o_ferr,
  output logic [7:0] o_data
);

  localparam int unsigned CntW = $clog2(CLKDIV);
  localparam logic [CntW-1:0] CntReload = CntW'(CLKDIV - 1);
  localparam logic [CntW-1:0] CntHalf   = CntW'(CLKDIV / 2 - 1);

  uart_state_e     r_state, w_state_d;
  logic [CntW-1:0] r_cnt, w_cnt_d;
  logic [2:0]      r_bit, w_bit_d;
  logic [7:0]      r_shift, w_shift_d;
  logic [1:0]      r_sync;
  logic            r_prev;
  logic            r_hunt, w_hunt_d;
  logic            w_line, w_tick;

  assign w_line = r_sync[1];
  assign w_tick = (r_cnt == '0);
  assign o_data = r_shift;

  always_comb begin
    w_state_d = r_state;
    w_cnt_d   = w_tick ? CntReload : r_cnt - CntW'(1);
    w_bit_d   = r_bit;
    w_shift_d = r_shift;
    w_hunt_d  = r_hunt;
    o_done    = 1'b0;
    o_ferr    = 1'b0;
    unique case (r_state)
      StIdle: begin
        w_cnt_d = CntHalf;
        if (r_prev && !w_line) w_state_d = StStart;
      end
      StStart: begin
        if (w_tick) begin
          if (w_line) begin
            w_state_d = StIdle;
          end else begin
            w_state_d = StData;
            w_bit_d   = 3'd0;
          end
        end
      end
      StData: begin
        if (w_tick) begin
          w_shift_d = {w_line, r_shift[7:1]};
          w_bit_d   = r_bit + 3'd1;
          if (r_bit == 3'd7) w_state_d = StStop;
        end
      end
      StStop: begin
        // After a bad stop bit, hold here until the line is released.
        if (r_hunt) begin
          if (w_line) begin
            w_hunt_d  = 1'b0;
            w_state_d = StIdle;
          end
        end else if (w_tick) begin
          if (w_line) begin
            o_done    = 1'b1;
            w_state_d = StIdle;
          end else begin
            o_ferr   = 1'b1;
            w_hunt_d = 1'b1;
          end
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= StIdle;
      r_cnt   <= CntHalf;
      r_bit   <= 3'd0;
      r_shift <= 8'h00;
      r_sync  <= 2'b11;
      r_prev  <= 1'b1;
      r_hunt  <= 1'b0;
    end else begin
      r_state <= w_state_d;
      r_cnt   <= w_cnt_d;
      r_bit   <= w_bit_d;
      r_shift <= w_shift_d;
      r_sync  <= {r_sync[0], i_rx};
      r_prev  <= w_line;
      r_hunt  <= w_hunt_d;
    end
  end

endmodule

// File: rtl/m_uart_tx.sv
// 8N1 transmitter: pulls a byte from the holding register when idle or at the
// end of a stop bit, so back-to-back bytes leave with no idle gap.
module m_uart_tx
  import m_wb_uart_pkg::*;
#(
  parameter int unsigned CLKDIV = 208
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_full,
  input  logic [7:0] i_data,
  output logic       o_take,
  output logic       o_busy,
  output logic       o_tx
);

  localparam int unsigned CntW = $clog2(CLKDIV);
  localparam logic [CntW-1:0] CntReload = CntW'(CLKDIV - 1);

  uart_state_e     r_state, w_state_d;
  logic [CntW-1:0] r_cnt, w_cnt_d;
  logic [2:0]      r_bit, w_bit_d;
  logic [7:0]      r_shift, w_shift_d;
  logic            r_tx, w_tx_d;
  logic            w_tick;

  assign w_tick = (r_cnt == '0);
  assign o_busy = (r_state != StIdle);
  assign o_tx   = r_tx;

  always_comb begin
    w_state_d = r_state;
    w_cnt_d   = w_tick ? CntReload : r_cnt - CntW'(1);
    w_bit_d   = r_bit;
    w_shift_d = r_shift;
    o_take    = 1'b0;
    unique case (r_state)
      StIdle: begin
        w_cnt_d = CntReload;
        if (i_full) begin
          o_take    = 1'b1;
          w_shift_d = i_data;
          w_state_d = StStart;
        end
      end
      StStart: begin
        if (w_tick) begin
          w_state_d = StData;
          w_bit_d   = 3'd0;
        end
      end
      StData: begin
        if (w_tick) begin
          w_shift_d = {1'b0, r_shift[7:1]};
          w_bit_d   = r_bit + 3'd1;
          if (r_bit == 3'd7) w_state_d = StStop;
        end
      end
      StStop: begin
        if (w_tick) begin
          if (i_full) begin
            o_take    = 1'b1;
            w_shift_d = i_data;
            w_state_d = StStart;
          end else begin
            w_state_d = StIdle;
          end
        end
      end
      default: w_state_d = StIdle;
    endcase

    // Line level is registered from the next state to keep the pin glitch-free.
    unique case (w_state_d)
      StStart: w_tx_d = 1'b0;
      StData:  w_tx_d = w_shift_d[0];
      default: w_tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= StIdle;
      r_cnt   <= CntReload;
      r_bit   <= 3'd0;
      r_shift <= 8'h00;
      r_tx    <= 1'b1;
    end else begin
      r_state <= w_state_d;
      r_cnt   <= w_cnt_d;
      r_bit   <= w_bit_d;
      r_shift <= w_shift_d;
      r_tx    <= w_tx_d;
    end
  end

endmodule

// File: rtl/m_wb_uart.sv
// Wishbone classic responder for the midgetv bus: DATA/STATUS registers, TX and
// RX holding registers and sticky error flags around the UART TX/RX engines.
module m_wb_uart
  import m_wb_uart_pkg::*;
#(
  parameter int unsigned CLKDIV = 208,
  parameter int unsigned DWIDTH = 32
) (
  input  logic              CLK_I,
  input  logic              RST_I,
  input  logic              CYC_I,
  input  logic              STB_I,
  input  logic              WE_I,
  input  logic              ADR_I,
  input  logic [DWIDTH-1:0] DAT_I,
  output logic [DWIDTH-1:0] DAT_O,
  output logic              ACK_O,
  input  logic              usartRX,
  output logic              usartTX
);

  logic              w_req, w_wr_data, w_rd_data, w_wr_stat, w_rd_stat;
  logic              r_ack;
  logic [DWIDTH-1:0] r_dat, w_dat_d;
  logic              r_txfull, r_rxvalid, r_overrun, r_framerr;
  logic [7:0]        r_txbyte, r_rxbyte;
  logic              w_take, w_txbusy, w_rx_done, w_rx_ferr;
  logic [7:0]        w_rx_byte;
  logic              w_unused_dat;

  assign w_req     = CYC_I & STB_I & ~r_ack;
  assign w_wr_data = w_req &  WE_I & (ADR_I == AddrData);
  assign w_rd_data = w_req & ~WE_I & (ADR_I == AddrData);
  assign w_wr_stat = w_req &  WE_I & (ADR_I == AddrStatus);
  assign w_rd_stat = w_req & ~WE_I & (ADR_I == AddrStatus);
  assign w_unused_dat = ^DAT_I;

  assign ACK_O = r_ack;
  assign DAT_O = r_dat;

  // Read data is captured only on an accepted read, so DAT_O is zero off-ACK.
  always_comb begin
    w_dat_d = '0;
    if (w_rd_data) begin
      w_dat_d[7:0] = r_rxbyte;
    end else if (w_rd_stat) begin
      w_dat_d[StatRxValid] = r_rxvalid;
      w_dat_d[StatTxFull]  = r_txfull;
      w_dat_d[StatTxBusy]  = w_txbusy;
      w_dat_d[StatOverrun] = r_overrun;
      w_dat_d[StatFramErr] = r_framerr;
    end
  end

  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) begin
      r_ack     <= 1'b0;
      r_dat     <= '0;
      r_txfull  <= 1'b0;
      r_txbyte  <= 8'h00;
      r_rxvalid <= 1'b0;
      r_rxbyte  <= 8'h00;
      r_overrun <= 1'b0;
      r_framerr <= 1'b0;
    end else begin
      r_ack <= w_req;
      r_dat <= w_dat_d;

      // A write coinciding with a reload refills the slot the shifter just emptied.
      if (w_wr_data && (!r_txfull || w_take)) begin
        r_txbyte <= DAT_I[7:0];
        r_txfull <= 1'b1;
      end else if (w_take) begin
        r_txfull <= 1'b0;
      end

      if (w_rx_done && (!r_rxvalid || w_rd_data)) begin
        r_rxbyte  <= w_rx_byte;
        r_rxvalid <= 1'b1;
      end else if (w_rd_data) begin
        r_rxvalid <= 1'b0;
      end

      if (w_rx_done && r_rxvalid && !w_rd_data) begin
        r_overrun <= 1'b1;
      end else if (w_wr_stat && DAT_I[StatOverrun]) begin
        r_overrun <= 1'b0;
      end

      if (w_rx_ferr) begin
        r_framerr <= 1'b1;
      end else if (w_wr_stat && DAT_I[StatFramErr]) begin
        r_framerr <= 1'b0;
      end
    end
  end

  m_uart_tx #(
    .CLKDIV (CLKDIV)
  ) u_tx (
    .i_clk  (CLK_I),
    .i_rst  (RST_I),
    .i_full (r_txfull),
    .i_data (r_txbyte),
    .o_take (w_take),
    .o_busy (w_txbusy),
    .o_tx   (usartTX)
  );

  m_uart_rx #(
    .CLKDIV (CLKDIV)
  ) u_rx (
    .i_clk  (CLK_I),
    .i_rst  (RST_I),
    .i_rx   (usartRX),
    .o_done (w_rx_done),
    .o_ferr (w_rx_ferr),
    .o_data (w_rx_byte)
  );

endmodule
